// File: rtl/vital_threshold_monitor.sv
// Vital-sign threshold monitor: classifies each accepted sample against inclusive limits
// and raises a latched low/high alarm after PERSIST consecutive out-of-range samples.
module vital_threshold_monitor #(
  parameter int WIDTH   = 8,
  parameter int PERSIST = 4,
  parameter int HYST    = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] low_limit,
  input  logic [WIDTH-1:0] high_limit,
  input  logic             clear,
  output logic             result_valid,
  output logic             below,
  output logic             in_range,
  output logic             above,
  output logic             alarm_low,
  output logic             alarm_high,
  output logic             pending,
  output logic             cfg_error
);

  typedef enum logic [2:0] {
    NORMAL,
    PEND_LOW,
    PEND_HIGH,
    ALARM_LOW,
    ALARM_HIGH
  } state_t;

  localparam logic [WIDTH:0] HYST_W    = (WIDTH + 1)'(HYST);
  localparam logic [3:0]     PERSIST_C = 4'(PERSIST);

  state_t           state, stateNext;
  logic [3:0]       cnt, cntNext;
  logic             accept;
  logic             isBelow, isAbove, isCfgErr;
  logic [WIDTH:0]   relLowSum;
  logic [WIDTH-1:0] relLow, relHigh;
  state_t           lowEntry, highEntry;

  always_comb begin
    accept    = sample_valid & ~clear;
    isBelow   = sample < low_limit;
    isAbove   = sample > high_limit;
    isCfgErr  = low_limit > high_limit;
    relLowSum = {1'b0, low_limit} + HYST_W;
    relLow    = relLowSum[WIDTH] ? '1 : relLowSum[WIDTH-1:0];
    relHigh   = ({1'b0, high_limit} >= HYST_W) ? (high_limit - HYST_W[WIDTH-1:0]) : '0;
    lowEntry  = (PERSIST == 1) ? ALARM_LOW : PEND_LOW;
    highEntry = (PERSIST == 1) ? ALARM_HIGH : PEND_HIGH;
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (clear) begin
      stateNext = NORMAL;
      cntNext   = '0;
    end else if (sample_valid && !isCfgErr) begin
      unique case (state)
        NORMAL: begin
          if (isBelow) begin
            stateNext = lowEntry;
            cntNext   = 4'd1;
          end else if (isAbove) begin
            stateNext = highEntry;
            cntNext   = 4'd1;
          end else begin
            cntNext = '0;
          end
        end
        PEND_LOW: begin
          if (isBelow) begin
            cntNext = cnt + 4'd1;
            if (cnt + 4'd1 == PERSIST_C) stateNext = ALARM_LOW;
          end else if (isAbove) begin
            stateNext = highEntry;
            cntNext   = 4'd1;
          end else begin
            stateNext = NORMAL;
            cntNext   = '0;
          end
        end
        PEND_HIGH: begin
          if (isAbove) begin
            cntNext = cnt + 4'd1;
            if (cnt + 4'd1 == PERSIST_C) stateNext = ALARM_HIGH;
          end else if (isBelow) begin
            stateNext = lowEntry;
            cntNext   = 4'd1;
          end else begin
            stateNext = NORMAL;
            cntNext   = '0;
          end
        end
        // A crossing to the opposite side wins over the hysteresis hold band.
        ALARM_LOW: begin
          if (isAbove) begin
            stateNext = highEntry;
            cntNext   = 4'd1;
          end else if (sample >= relLow) begin
            stateNext = NORMAL;
            cntNext   = '0;
          end
        end
        ALARM_HIGH: begin
          if (isBelow) begin
            stateNext = lowEntry;
            cntNext   = 4'd1;
          end else if (sample <= relHigh) begin
            stateNext = NORMAL;
            cntNext   = '0;
          end
        end
        default: begin
          stateNext = NORMAL;
          cntNext   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= NORMAL;
      cnt          <= '0;
      result_valid <= 1'b0;
      below        <= 1'b0;
      in_range     <= 1'b0;
      above        <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      result_valid <= accept;
      if (clear) begin
        below    <= 1'b0;
        in_range <= 1'b0;
        above    <= 1'b0;
      end else if (accept) begin
        cfg_error <= isCfgErr;
        below     <= !isCfgErr && isBelow;
        above     <= !isCfgErr && isAbove;
        in_range  <= !isCfgErr && !isBelow && !isAbove;
      end
    end
  end

  always_comb begin
    alarm_low  = (state == ALARM_LOW);
    alarm_high = (state == ALARM_HIGH);
    pending    = (state == PEND_LOW) || (state == PEND_HIGH);
  end

endmodule

// File: tb/tb_vital_threshold_monitor.sv
// Self-checking bench for vital_threshold_monitor: directed scenarios plus randomized
// traffic compared against a run-length reference model.
module tb_vital_threshold_monitor;

  localparam int W  = 8;
  localparam int PS = 3;
  localparam int HY = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         sample_valid = 1'b0;
  logic [W-1:0] sample = '0;
  logic [W-1:0] low_limit = 8'd60;
  logic [W-1:0] high_limit = 8'd100;
  logic         clear = 1'b0;
  logic         result_valid, below, in_range, above;
  logic         alarm_low, alarm_high, pending, cfg_error;

  int errors = 0;
  int checks = 0;

  // reference model: alarm kind and current run (0 none, 1 low, 2 high)
  int mAlarm, mDir, mRun;
  logic mRv, mBelow, mIn, mAbove, mCfg;

  vital_threshold_monitor #(.WIDTH(W), .PERSIST(PS), .HYST(HY)) dut (
    .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid), .sample(sample),
    .low_limit(low_limit), .high_limit(high_limit), .clear(clear),
    .result_valid(result_valid), .below(below), .in_range(in_range), .above(above),
    .alarm_low(alarm_low), .alarm_high(alarm_high), .pending(pending), .cfg_error(cfg_error)
  );

  always #5 clock = ~clock;

  // {result_valid, below, in_range, above, alarm_low, alarm_high, pending, cfg_error}
  function automatic logic [7:0] obs();
    return {result_valid, below, in_range, above, alarm_low, alarm_high, pending, cfg_error};
  endfunction

  function automatic logic [7:0] expVec();
    logic pend;
    pend = (mAlarm == 0) && (mDir != 0);
    return {mRv, mBelow, mIn, mAbove, mAlarm == 1, mAlarm == 2, pend, mCfg};
  endfunction

  task automatic model_reset();
    mAlarm = 0; mDir = 0; mRun = 0;
    mRv = 0; mBelow = 0; mIn = 0; mAbove = 0; mCfg = 0;
  endtask

  task automatic start_run(input int d);
    mAlarm = 0; mDir = d; mRun = 1;
    if (mRun >= PS) mAlarm = d;
  endtask

  task automatic model_step(input logic v, input logic c, input int s, input int lo, input int hi);
    int relLo, relHi, d;
    if (c) begin
      mAlarm = 0; mDir = 0; mRun = 0;
      mRv = 0; mBelow = 0; mIn = 0; mAbove = 0;
    end else if (v) begin
      mRv = 1;
      if (lo > hi) begin
        mCfg = 1; mBelow = 0; mIn = 0; mAbove = 0;
      end else begin
        mCfg = 0;
        mBelow = (s < lo); mAbove = (s > hi); mIn = !(s < lo) && !(s > hi);
        relLo = (lo + HY > 255) ? 255 : lo + HY;
        relHi = (hi - HY < 0) ? 0 : hi - HY;
        d = (s < lo) ? 1 : (s > hi) ? 2 : 0;
        if (mAlarm == 1) begin
          if (d == 2) start_run(2);
          else if (s >= relLo) begin mAlarm = 0; mDir = 0; mRun = 0; end
        end else if (mAlarm == 2) begin
          if (d == 1) start_run(1);
          else if (s <= relHi) begin mAlarm = 0; mDir = 0; mRun = 0; end
        end else if (d == 0) begin
          mDir = 0; mRun = 0;
        end else if (d == mDir) begin
          mRun++;
          if (mRun == PS) mAlarm = d;
        end else begin
          start_run(d);
        end
      end
    end else begin
      mRv = 0;
    end
  endtask

  task automatic step(input logic v, input logic c, input logic [W-1:0] s);
    @(negedge clock);
    sample_valid = v; clear = c; sample = s;
    @(posedge clock);
    #1;
    model_step(v, c, int'(s), int'(low_limit), int'(high_limit));
    sample_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++;
    if (obs() !== 8'b0000_0000) begin
      errors++; $display("FAIL reset_state got=%b want=%b", obs(), 8'b0);
    end
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_low_alarm();
    low_limit = 8'd60; high_limit = 8'd100;
    step(1, 0, 8'd50);
    checks++; if (obs() !== 8'b1100_0010) begin errors++; $display("FAIL low_1st got=%b want=%b", obs(), 8'b1100_0010); end
    step(1, 0, 8'd50);
    checks++; if (obs() !== 8'b1100_0010) begin errors++; $display("FAIL low_2nd got=%b want=%b", obs(), 8'b1100_0010); end
    step(1, 0, 8'd50);
    checks++; if (obs() !== 8'b1100_1000) begin errors++; $display("FAIL low_3rd_alarm got=%b want=%b", obs(), 8'b1100_1000); end
    step(1, 0, 8'd62);
    checks++; if (obs() !== 8'b1010_1000) begin errors++; $display("FAIL low_hyst_hold got=%b want=%b", obs(), 8'b1010_1000); end
    step(1, 0, 8'd64);
    checks++; if (obs() !== 8'b1010_0000) begin errors++; $display("FAIL low_release got=%b want=%b", obs(), 8'b1010_0000); end
    step(0, 0, 8'd7);
    checks++; if (obs() !== 8'b0010_0000) begin errors++; $display("FAIL idle_hold got=%b want=%b", obs(), 8'b0010_0000); end
  endtask

  task automatic test_high_alarm_gap();
    step(1, 0, 8'd101);
    step(1, 0, 8'd101);
    checks++; if (obs() !== 8'b1001_0010) begin errors++; $display("FAIL high_2nd got=%b want=%b", obs(), 8'b1001_0010); end
    repeat (5) step(0, 0, 8'd0);
    checks++; if (obs() !== 8'b0001_0010) begin errors++; $display("FAIL gap_hold got=%b want=%b", obs(), 8'b0001_0010); end
    step(1, 0, 8'd101);
    checks++; if (obs() !== 8'b1001_0100) begin errors++; $display("FAIL high_alarm got=%b want=%b", obs(), 8'b1001_0100); end
    step(1, 0, 8'd100);
    checks++; if (obs() !== 8'b1010_0100) begin errors++; $display("FAIL high_hyst_hold got=%b want=%b", obs(), 8'b1010_0100); end
    step(1, 0, 8'd96);
    checks++; if (obs() !== 8'b1010_0000) begin errors++; $display("FAIL high_release got=%b want=%b", obs(), 8'b1010_0000); end
  endtask

  task automatic test_switch();
    step(1, 0, 8'd50);
    step(1, 0, 8'd50);
    step(1, 0, 8'd120);
    checks++; if (obs() !== 8'b1001_0010) begin errors++; $display("FAIL pend_switch got=%b want=%b", obs(), 8'b1001_0010); end
    step(1, 0, 8'd80);
    repeat (3) step(1, 0, 8'd50);
    step(1, 0, 8'd150);
    checks++; if (obs() !== 8'b1001_0010) begin errors++; $display("FAIL alarm_switch got=%b want=%b", obs(), 8'b1001_0010); end
    step(1, 0, 8'd80);
    checks++; if (obs() !== 8'b1010_0000) begin errors++; $display("FAIL switch_normal got=%b want=%b", obs(), 8'b1010_0000); end
  endtask

  task automatic test_boundaries();
    step(1, 0, 8'd60);
    checks++; if (obs() !== 8'b1010_0000) begin errors++; $display("FAIL edge_low got=%b want=%b", obs(), 8'b1010_0000); end
    step(1, 0, 8'd100);
    checks++; if (obs() !== 8'b1010_0000) begin errors++; $display("FAIL edge_high got=%b want=%b", obs(), 8'b1010_0000); end
    low_limit = 8'd254; high_limit = 8'd255;
    repeat (3) step(1, 0, 8'd10);
    step(1, 0, 8'd254);
    checks++; if (obs() !== 8'b1010_1000) begin errors++; $display("FAIL rel_low_sat_hold got=%b want=%b", obs(), 8'b1010_1000); end
    step(1, 0, 8'd255);
    checks++; if (obs() !== 8'b1010_0000) begin errors++; $display("FAIL rel_low_sat_release got=%b want=%b", obs(), 8'b1010_0000); end
    low_limit = 8'd0; high_limit = 8'd2;
    repeat (3) step(1, 0, 8'd3);
    step(1, 0, 8'd1);
    checks++; if (obs() !== 8'b1010_0100) begin errors++; $display("FAIL rel_high_sat_hold got=%b want=%b", obs(), 8'b1010_0100); end
    step(1, 0, 8'd0);
    checks++; if (obs() !== 8'b1010_0000) begin errors++; $display("FAIL rel_high_sat_release got=%b want=%b", obs(), 8'b1010_0000); end
    low_limit = 8'd60; high_limit = 8'd100;
  endtask

  task automatic test_cfg_error();
    step(1, 0, 8'd50);
    low_limit = 8'd110; high_limit = 8'd100;
    step(1, 0, 8'd50);
    checks++; if (obs() !== 8'b1000_0011) begin errors++; $display("FAIL cfg_error got=%b want=%b", obs(), 8'b1000_0011); end
    low_limit = 8'd60;
    step(1, 0, 8'd50);
    checks++; if (obs() !== 8'b1100_0010) begin errors++; $display("FAIL cfg_cnt_kept got=%b want=%b", obs(), 8'b1100_0010); end
    step(1, 0, 8'd50);
    checks++; if (obs() !== 8'b1100_1000) begin errors++; $display("FAIL cfg_then_alarm got=%b want=%b", obs(), 8'b1100_1000); end
    step(1, 0, 8'd80);
  endtask

  task automatic test_clear();
    step(1, 0, 8'd50);
    step(1, 1, 8'd50);
    checks++; if (obs() !== 8'b0000_0000) begin errors++; $display("FAIL clear got=%b want=%b", obs(), 8'b0000_0000); end
    step(1, 0, 8'd50);
    step(1, 0, 8'd50);
    checks++; if (obs() !== 8'b1100_0010) begin errors++; $display("FAIL clear_cnt_zero got=%b want=%b", obs(), 8'b1100_0010); end
    step(1, 0, 8'd80);
  endtask

  task automatic test_reset_mid();
    step(1, 0, 8'd50);
    step(1, 0, 8'd50);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (obs() !== 8'b0000_0000) begin errors++; $display("FAIL async_reset got=%b want=%b", obs(), 8'b0000_0000); end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step(1, 0, 8'd50);
    checks++; if (obs() !== 8'b1100_0010) begin errors++; $display("FAIL reset_cnt_zero got=%b want=%b", obs(), 8'b1100_0010); end
    step(1, 0, 8'd80);
  endtask

  task automatic test_random();
    int lo, hi, r;
    logic [W-1:0] s;
    for (int blk = 0; blk < 15; blk++) begin
      lo = $urandom_range(0, 200);
      hi = lo + $urandom_range(0, 55);
      if ($urandom_range(0, 9) == 0) begin r = lo; lo = hi + 1; hi = r; end
      if (lo > 255) lo = 255;
      low_limit = W'(lo); high_limit = W'(hi);
      for (int i = 0; i < 20; i++) begin
        r = $urandom_range(0, 2);
        if (r == 0) s = W'($urandom_range(0, lo));
        else if (r == 1) s = W'($urandom_range(hi, 255));
        else s = W'($urandom_range(0, 255));
        step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, s);
        checks++;
        if (obs() !== expVec()) begin
          errors++;
          $display("FAIL random blk=%0d i=%0d lo=%0d hi=%0d s=%0d got=%b want=%b", blk, i, lo, hi, s, obs(), expVec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_low_alarm();
    test_high_alarm_gap();
    test_switch();
    test_boundaries();
    test_cfg_error();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vital_threshold_monitor.md
VITAL_THRESHOLD_MONITOR -- requirements
Module: vital_threshold_monitor

Interface
REQ-001 The parameter WIDTH SHALL have default 8 and SHALL set the sample and limit width in bits (legal range 2..16).
REQ-002 The parameter PERSIST SHALL have default 4 and SHALL set the number of consecutive out-of-range samples that raise an alarm (legal range 1..15).
REQ-003 The parameter HYST SHALL have default 2 and SHALL set the unsigned hysteresis margin for alarm release (legal range 0..2^WIDTH-1).
REQ-004 The port clock SHALL be an input, 1 bit wide: the single clock, rising edge.
REQ-005 The port reset_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-006 The port sample_valid SHALL be an input, 1 bit wide: a new sample is present this cycle.
REQ-007 The port sample SHALL be an input, WIDTH bits wide: an unsigned vital-sign reading.
REQ-008 The port low_limit SHALL be an input, WIDTH bits wide: the unsigned lower bound, inclusive in-range.
REQ-009 The port high_limit SHALL be an input, WIDTH bits wide: the unsigned upper bound, inclusive in-range.
REQ-010 The port clear SHALL be an input, 1 bit wide: a synchronous abort that returns the block to NORMAL.
REQ-011 The port result_valid SHALL be an output, 1 bit wide: a one-cycle pulse that marks updated classification outputs.
REQ-012 The ports below, in_range and above SHALL be outputs, 1 bit each: the registered classification of the last accepted sample.
REQ-013 The ports alarm_low and alarm_high SHALL be outputs, 1 bit each: latched alarm flags.
REQ-014 The port pending SHALL be an output, 1 bit wide: a persistence count is in progress.
REQ-015 The port cfg_error SHALL be an output, 1 bit wide: registered, high when low_limit > high_limit at the last accepted sample.

Function
REQ-016 A sample SHALL be accepted on a rising edge with sample_valid=1 and clear=0; all outputs SHALL update on that edge, and result_valid SHALL be high for exactly the following cycle (latency 1).
REQ-017 Classification SHALL be: below if sample<low_limit, above if sample>high_limit, otherwise in_range; the three flags SHALL be one-hot when cfg_error=0.
REQ-018 If low_limit>high_limit at acceptance: cfg_error=1, below/in_range/above=0, FSM state, counter and alarms unchanged, and result_valid still pulses.
REQ-019 With sample_valid=0, the FSM, counter and all outputs except result_valid SHALL hold (gaps do not break persistence).
REQ-020 The FSM SHALL have states NORMAL, PEND_LOW, PEND_HIGH, ALARM_LOW and ALARM_HIGH, with a 4-bit persistence counter cnt.
REQ-021 In NORMAL: below -> PEND_LOW with cnt=1; above -> PEND_HIGH with cnt=1; in_range -> stay with cnt=0; with PERSIST=1, go directly to ALARM_LOW/ALARM_HIGH.
REQ-022 In PEND_LOW: below -> cnt+1, entering ALARM_LOW when cnt+1=PERSIST; in_range -> NORMAL with cnt=0; above -> PEND_HIGH with cnt=1 (PEND_HIGH is symmetric).
REQ-023 In ALARM_LOW: stay while sample<rel_low; sample>=rel_low and <=high_limit -> NORMAL; above -> PEND_HIGH with cnt=1 (or ALARM_HIGH if PERSIST=1).
REQ-024 In ALARM_HIGH: stay while sample>rel_high; sample<=rel_high and >=low_limit -> NORMAL; below -> PEND_LOW with cnt=1 (or ALARM_LOW if PERSIST=1).
REQ-025 rel_low SHALL be computed at WIDTH+1 bits as low_limit+HYST, saturated to 2^WIDTH-1; rel_high SHALL be computed as high_limit-HYST, saturated to 0.
REQ-026 Outputs SHALL be decoded from state: alarm_low=ALARM_LOW, alarm_high=ALARM_HIGH, pending=PEND_LOW or PEND_HIGH; the two alarms SHALL never be high together.
REQ-027 The limits SHALL be sampled only at acceptance; a limit change while pending or in alarm takes effect on the next accepted sample.
REQ-028 clear=1 SHALL force NORMAL, cnt=0 and all classification flags 0 on the next edge, ignore a simultaneous sample_valid, and produce no result_valid.
REQ-029 cnt SHALL never exceed PERSIST.

Reset
REQ-030 While reset_n=0, the block SHALL be in NORMAL with cnt=0 and every output 0, asynchronously; operation SHALL resume on the first rising edge after deassertion, and a reset asserted mid-persistence SHALL discard the count.

Verification
REQ-031 Bench defaults SHALL be WIDTH=8, PERSIST=3, HYST=4, low=60, high=100.
REQ-032 Samples 50,50,50 -> below each time, pending=1 after the 1st and 2nd, alarm_low=1 after the 3rd; then 62 -> alarm held; then 64 -> NORMAL, in_range=1.
REQ-033 Samples 101,101,idle 5 cycles,101 -> alarm_high set on the 3rd valid sample; then 100 -> alarm held; then 96 -> NORMAL.
REQ-034 Samples 50,50,120 -> PEND_HIGH with cnt=1, alarm_low never asserted; in ALARM_LOW, sample 150 -> alarm_low=0, pending=1.
REQ-035 Boundaries: 60 and 100 -> in_range; low=254 with HYST=4 -> rel_low saturates at 255; high=2 -> rel_high=0.
REQ-036 Set low=110, high=100, then sample 50 -> cfg_error=1, all class flags 0, state unchanged; drive clear or reset_n=0 mid-PEND_LOW -> NORMAL, cnt=0, no result_valid.
